kitchen_responder: RTL and testbench
====================================

Name: kitchen_responder

Overview:
- Game-side end of the in_bits/out_bits kitchen command link: decodes 8-bit commands issued by the script executor and produces the 8-bit status word it polls.
- Models game phase, player position, target selection, movement, a held item, and per-station contents and processing timers.
- Used as the bench/standalone model of the kitchen so script execution runs without the host game.

Parameters:
- NUM_TARGETS, 20, number of selectable stations; ids 0..NUM_TARGETS-1.
- NUM_DISPENSERS, 4, ids 0..NUM_DISPENSERS-1 are infinite-stock dispensers.
- NUM_MACHINES, 6, ids NUM_DISPENSERS..NUM_DISPENSERS+NUM_MACHINES-1 are processing machines; remaining ids are plain counters.
- MOVE_CYCLES, 16, cycles from move acceptance to arrival (>=1).
- PROCESS_CYCLES, 64, machine processing time (>=1).
- THROW_CYCLES, 8, cycles from throw acceptance to release (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- in_bits  in  8  command word, held at level by the initiator.
- out_bits  out  8  status: [0] game running, [1] moving, [2] player at selected target, [3] player holding item, [4] selected target ready (machine done), [7:5] zero.
- cmd_ack  out  1  one-cycle pulse: command accepted.
- cmd_err  out  1  one-cycle pulse: command decoded but rejected.

Behaviour:
- Reset (async, any time, mid-move included): phase=IDLE, pos=0, target=0, holding=0, all station contents/timers/done cleared, in_q=0, all outputs 0.
- A command is new when in_bits != in_q (in_q registered every cycle). It is evaluated only in its new cycle; a held level is never re-executed. Effects and ack/err are visible the cycle after.
- Encoding by in_bits[1:0]:
  - 00: idle.
  - 01: control. 0x05 start, 0x09 end.
  - 11: select, target=in_bits[7:2].
  - 10: action, one-hot in [6:2]: get 0x06, put 0x0A, interact 0x12, move 0x22, throw 0x42.
  - Any other pattern -> cmd_err.
- Phase FSM: IDLE -start-> RUNNING -end-> ENDED; ENDED exits only via reset.
  - Start outside IDLE -> err.
  - End outside RUNNING -> err.
  - Any non-control command outside RUNNING -> err.
- Select: id >= NUM_TARGETS -> err, target unchanged. Select during a move -> err. Otherwise target updated; out[2] = (pos==target) && !moving.
- Move: target==pos -> ack with no motion. Already moving -> err. Else moving=1 for MOVE_CYCLES cycles, then pos<=target, moving=0.
- Get: needs at-target, !holding, and station stock (dispenser always; otherwise contents=1 and, for machines, not busy). Sets holding=1 and clears non-dispenser contents and done. Else err.
- Put: needs at-target, holding, station not a dispenser, contents=0. Sets contents=1, holding=0. Else err.
- Interact: needs at-target, machine, contents=1, !busy, !done. Loads timer=PROCESS_CYCLES. When the timer reaches 0, done=1. Else err.
- Throw: needs holding and !moving. Starts the throw counter; holding clears after THROW_CYCLES. A target with contents=0 that is not a dispenser then gets contents=1; otherwise the item is discarded. A second throw while one is pending -> err.
- out[4] = done of the selected target (0 for non-machines).
- Machine timers run in parallel and independently of the player. Move and throw counters are independent of each other.
- Simultaneous events: a command in the same cycle as timer expiry sees the pre-expiry state.
- ack and err are mutually exclusive; idle encoding produces neither.

Decomposition:
- Shared package kitchen_pkg:
  - command codes: CMD_START, CMD_END, CMD_GET, CMD_PUT, CMD_INTERACT, CMD_MOVE, CMD_THROW.
  - type field codes: TYPE_IDLE, TYPE_CTRL, TYPE_ACTION, TYPE_SELECT.
  - out_bits bit indices.
  - phase enum (IDLE, RUNNING, ENDED).
- Sub-module kitchen_station: one per target via generate. Holds the contents bit, busy timer and done flag; takes put/get/interact/throw-deposit strobes and exposes contents/busy/done.

Test Plan:
1. Reset, then in_bits 0x22 -> cmd_err; out_bits stays 0x00. Then 0x05 -> ack, out_bits=0x01.
2. Running: select id 2 (0x0B), move (0x22) -> out[1]=1 for 16 cycles, then out_bits=0x05. Get (0x06) -> out_bits=0x0D.
3. Holding at pos 2: select id 5 (0x17), move, put (0x0A) -> out[3]=0. Interact (0x12) -> out[4]=0 for 64 cycles, then 1. Get -> out[3]=1, out[4]=0.
4. Hold 0x06 for 100 cycles -> exactly one ack. Repeat get while holding -> err.
5. Throw (0x42) while holding, select id 10 -> out[3] clears after 8 cycles and station 10 contents=1. Throw again with empty hands -> err.
6. Assert rst mid-move (cycle 7 of 16) -> out_bits=0x00 immediately. Select 0xFF (id 63) when running -> err. End (0x09) -> out[0]=0, then start -> err.

Source files
------------

// File: rtl/kitchen_pkg.sv
// Shared command encodings, status bit positions and phase type for the
// kitchen command link.
package kitchen_pkg;

  localparam logic [7:0] CMD_START    = 8'h05;
  localparam logic [7:0] CMD_END      = 8'h09;
  localparam logic [7:0] CMD_GET      = 8'h06;
  localparam logic [7:0] CMD_PUT      = 8'h0A;
  localparam logic [7:0] CMD_INTERACT = 8'h12;
  localparam logic [7:0] CMD_MOVE     = 8'h22;
  localparam logic [7:0] CMD_THROW    = 8'h42;

  localparam logic [1:0] TYPE_IDLE   = 2'b00;
  localparam logic [1:0] TYPE_CTRL   = 2'b01;
  localparam logic [1:0] TYPE_ACTION = 2'b10;
  localparam logic [1:0] TYPE_SELECT = 2'b11;

  localparam int unsigned OUT_RUNNING   = 0;
  localparam int unsigned OUT_MOVING    = 1;
  localparam int unsigned OUT_AT_TARGET = 2;
  localparam int unsigned OUT_HOLDING   = 3;
  localparam int unsigned OUT_READY     = 4;

  typedef enum logic [1:0] {
    PHASE_IDLE,
    PHASE_RUNNING,
    PHASE_ENDED
  } phase_e;

endpackage

// File: rtl/kitchen_responder_if.sv
// Command/status link between the script executor (master) and the kitchen
// responder (slave).
interface kitchen_responder_if;
  logic [7:0] in_bits;
  logic [7:0] out_bits;
  logic       cmd_ack;
  logic       cmd_err;

  modport master (output in_bits, input out_bits, cmd_ack, cmd_err);
  modport slave  (input in_bits, output out_bits, cmd_ack, cmd_err);
endinterface

// File: rtl/kitchen_station.sv
// One kitchen station: contents bit plus, for machines, a processing timer
// and a done flag.
module kitchen_station #(
  parameter bit          IS_MACHINE     = 1'b0,
  parameter int unsigned PROCESS_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic put_i,
  input  logic get_i,
  input  logic interact_i,
  input  logic deposit_i,
  output logic contents_o,
  output logic busy_o,
  output logic done_o
);
  localparam int unsigned TW = $clog2(PROCESS_CYCLES + 1);

  logic          contents_q, contents_d;
  logic          done_q, done_d;
  logic [TW-1:0] timer_q, timer_d;

  always_comb begin
    contents_d = contents_q;
    done_d     = done_q;
    timer_d    = timer_q;
    if (timer_q != '0) begin
      timer_d = timer_q - 1'b1;
      if (timer_q == TW'(1)) done_d = 1'b1;
    end
    if (put_i || deposit_i) contents_d = 1'b1;
    if (get_i) begin
      contents_d = 1'b0;
      done_d     = 1'b0;
    end
    if (IS_MACHINE && interact_i) timer_d = TW'(PROCESS_CYCLES);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      contents_q <= 1'b0;
      done_q     <= 1'b0;
      timer_q    <= '0;
    end else begin
      contents_q <= contents_d;
      done_q     <= done_d;
      timer_q    <= timer_d;
    end
  end

  assign contents_o = contents_q;
  assign busy_o     = timer_q != '0;
  assign done_o     = done_q;

endmodule

// File: rtl/kitchen_responder.sv
// Game-side model of the kitchen: decodes edge-detected command words and
// reports phase, movement, holding and station status.
module kitchen_responder
  import kitchen_pkg::*;
#(
  parameter int unsigned NUM_TARGETS    = 20,
  parameter int unsigned NUM_DISPENSERS = 4,
  parameter int unsigned NUM_MACHINES   = 6,
  parameter int unsigned MOVE_CYCLES    = 16,
  parameter int unsigned PROCESS_CYCLES = 64,
  parameter int unsigned THROW_CYCLES   = 8
) (
  input logic                clk,
  input logic                rst,
  kitchen_responder_if.slave link
);
  localparam int unsigned ID_W    = 6;
  localparam int unsigned MOVE_W  = $clog2(MOVE_CYCLES + 1);
  localparam int unsigned THROW_W = $clog2(THROW_CYCLES + 1);

  phase_e             phase_q, phase_d;
  logic [7:0]         in_q;
  logic [ID_W-1:0]    pos_q, pos_d, target_q, target_d;
  logic               target_valid_q, target_valid_d;
  logic               holding_q, holding_d;
  logic               ack_q, ack_d, err_q, err_d;
  logic [MOVE_W-1:0]  move_cnt_q, move_cnt_d;
  logic [THROW_W-1:0] throw_cnt_q, throw_cnt_d;

  logic [NUM_TARGETS-1:0] tgt_hot, put_s, get_s, interact_s, deposit_s;
  logic [NUM_TARGETS-1:0] contents, busy, done;
  logic moving, throwing, at_target, cmd_new, accept;
  logic sel_disp, sel_mach, sel_contents, sel_busy, sel_done;

  for (genvar i = 0; i < NUM_TARGETS; i++) begin : g_station
    assign tgt_hot[i] = (target_q == ID_W'(i));
    kitchen_station #(
      .IS_MACHINE    ((i >= NUM_DISPENSERS) && (i < NUM_DISPENSERS + NUM_MACHINES)),
      .PROCESS_CYCLES(PROCESS_CYCLES)
    ) u_station (
      .clk       (clk),
      .rst       (rst),
      .put_i     (put_s[i]),
      .get_i     (get_s[i]),
      .interact_i(interact_s[i]),
      .deposit_i (deposit_s[i]),
      .contents_o(contents[i]),
      .busy_o    (busy[i]),
      .done_o    (done[i])
    );
  end

  assign moving       = move_cnt_q != '0;
  assign throwing     = throw_cnt_q != '0;
  // Position only counts as "at target" once a target has been explicitly selected.
  assign at_target    = target_valid_q && (pos_q == target_q) && !moving;
  assign cmd_new      = link.in_bits != in_q;
  assign sel_disp     = target_q < ID_W'(NUM_DISPENSERS);
  assign sel_mach     = !sel_disp && (target_q < ID_W'(NUM_DISPENSERS + NUM_MACHINES));
  assign sel_contents = |(contents & tgt_hot);
  assign sel_busy     = |(busy & tgt_hot);
  assign sel_done     = |(done & tgt_hot);

  always_comb begin
    phase_d        = phase_q;
    pos_d          = pos_q;
    target_d       = target_q;
    target_valid_d = target_valid_q;
    holding_d      = holding_q;
    move_cnt_d     = move_cnt_q;
    throw_cnt_d    = throw_cnt_q;
    put_s          = '0;
    get_s          = '0;
    interact_s     = '0;
    deposit_s      = '0;
    accept         = 1'b0;
    ack_d          = 1'b0;
    err_d          = 1'b0;

    if (moving) begin
      move_cnt_d = move_cnt_q - 1'b1;
      if (move_cnt_q == MOVE_W'(1)) pos_d = target_q;
    end
    if (throwing) begin
      throw_cnt_d = throw_cnt_q - 1'b1;
      if (throw_cnt_q == THROW_W'(1)) begin
        holding_d = 1'b0;
        if (!sel_disp && !sel_contents) deposit_s = tgt_hot;
      end
    end

    if (cmd_new && link.in_bits[1:0] != TYPE_IDLE) begin
      unique case (link.in_bits[1:0])
        TYPE_CTRL: begin
          if (link.in_bits == CMD_START && phase_q == PHASE_IDLE) begin
            phase_d = PHASE_RUNNING;
            accept  = 1'b1;
          end else if (link.in_bits == CMD_END && phase_q == PHASE_RUNNING) begin
            phase_d = PHASE_ENDED;
            accept  = 1'b1;
          end
        end
        TYPE_SELECT: begin
          if (phase_q == PHASE_RUNNING && !moving &&
              link.in_bits[7:2] < ID_W'(NUM_TARGETS)) begin
            target_d       = link.in_bits[7:2];
            target_valid_d = 1'b1;
            accept         = 1'b1;
          end
        end
        default: begin
          if (phase_q == PHASE_RUNNING) begin
            case (link.in_bits)
              CMD_GET: if (at_target && !holding_q &&
                           (sel_disp || (sel_contents && !sel_busy))) begin
                holding_d = 1'b1;
                get_s     = tgt_hot;
                accept    = 1'b1;
              end
              // An item already in flight cannot also be put down.
              CMD_PUT: if (at_target && holding_q && !throwing &&
                           !sel_disp && !sel_contents) begin
                holding_d = 1'b0;
                put_s     = tgt_hot;
                accept    = 1'b1;
              end
              CMD_INTERACT: if (at_target && sel_mach && sel_contents &&
                                !sel_busy && !sel_done) begin
                interact_s = tgt_hot;
                accept     = 1'b1;
              end
              CMD_MOVE: begin
                if (target_q == pos_q) begin
                  accept = 1'b1;
                end else if (!moving) begin
                  move_cnt_d = MOVE_W'(MOVE_CYCLES);
                  accept     = 1'b1;
                end
              end
              CMD_THROW: if (holding_q && !moving && !throwing) begin
                throw_cnt_d = THROW_W'(THROW_CYCLES);
                accept      = 1'b1;
              end
              default: ;
            endcase
          end
        end
      endcase
      ack_d = accept;
      err_d = !accept;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q        <= PHASE_IDLE;
      in_q           <= '0;
      pos_q          <= '0;
      target_q       <= '0;
      target_valid_q <= 1'b0;
      holding_q      <= 1'b0;
      move_cnt_q     <= '0;
      throw_cnt_q    <= '0;
      ack_q          <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      in_q           <= link.in_bits;
      pos_q          <= pos_d;
      target_q       <= target_d;
      target_valid_q <= target_valid_d;
      holding_q      <= holding_d;
      move_cnt_q     <= move_cnt_d;
      throw_cnt_q    <= throw_cnt_d;
      ack_q          <= ack_d;
      err_q          <= err_d;
    end
  end

  always_comb begin
    link.out_bits                = '0;
    link.out_bits[OUT_RUNNING]   = phase_q == PHASE_RUNNING;
    link.out_bits[OUT_MOVING]    = moving;
    link.out_bits[OUT_AT_TARGET] = at_target;
    link.out_bits[OUT_HOLDING]   = holding_q;
    link.out_bits[OUT_READY]     = sel_done;
  end

  assign link.cmd_ack = ack_q;
  assign link.cmd_err = err_q;

endmodule

// File: tb/tb_kitchen_responder.sv
// Bench for kitchen_responder: directed scenario walk-through followed by
// randomized command streams against a time-stamp based kitchen model.
module tb_kitchen_responder;
  import kitchen_pkg::*;

  localparam int NT = 20;
  localparam int ND = 4;
  localparam int NM = 6;
  localparam int MC = 16;
  localparam int PC = 64;
  localparam int TC = 8;

  logic clk = 1'b0;
  logic rst;
  bit   cmp_en = 1'b0;
  int   checks = 0;
  int   passes = 0;

  kitchen_responder_if link();

  kitchen_responder #(
    .NUM_TARGETS   (NT),
    .NUM_DISPENSERS(ND),
    .NUM_MACHINES  (NM),
    .MOVE_CYCLES   (MC),
    .PROCESS_CYCLES(PC),
    .THROW_CYCLES  (TC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .link(link)
  );

  always #5 clk = ~clk;

  // Model: absolute edge count t, events stored as the edge at which they end.
  int         t;
  int         m_phase;  // 0 idle, 1 running, 2 ended
  int         m_pos, m_tgt;
  bit         m_tvld, m_hold, m_ack, m_err;
  int         m_move_end, m_throw_end;
  bit         m_cont [NT];
  bit         m_loaded [NT];
  int         m_ready [NT];
  logic [7:0] m_inq;

  task automatic m_reset();
    t = 0; m_phase = 0; m_pos = 0; m_tgt = 0; m_tvld = 0; m_hold = 0;
    m_ack = 0; m_err = 0; m_move_end = 0; m_throw_end = 0; m_inq = 8'h00;
    for (int i = 0; i < NT; i++) begin
      m_cont[i] = 0; m_loaded[i] = 0; m_ready[i] = 0;
    end
  endtask

  function automatic logic [7:0] m_out();
    logic [7:0] o;
    bit mv;
    mv = t < m_move_end;
    o = 8'h00;
    o[0] = (m_phase == 1);
    o[1] = mv;
    o[2] = m_tvld && (m_pos == m_tgt) && !mv;
    o[3] = m_hold;
    o[4] = m_loaded[m_tgt] && (t >= m_ready[m_tgt]);
    return o;
  endfunction

  task automatic m_step(input logic [7:0] v);
    bit nw, ok, mv, at, disp, mach, pend, busy, done, rel_dep, rel;
    int tg;
    nw   = (v != m_inq);
    m_inq = v;
    tg   = m_tgt;
    mv   = t < m_move_end;
    pend = t < m_throw_end;
    at   = m_tvld && (m_pos == tg) && !mv;
    disp = tg < ND;
    mach = (tg >= ND) && (tg < ND + NM);
    busy = m_loaded[tg] && (t < m_ready[tg]);
    done = m_loaded[tg] && (t >= m_ready[tg]);
    rel     = (m_throw_end == t + 1);
    rel_dep = rel && !disp && !m_cont[tg];
    m_ack = 0; m_err = 0;
    if (nw && v[1:0] != 2'b00) begin
      ok = 0;
      if (v[1:0] == 2'b01) begin
        if (v == CMD_START && m_phase == 0) begin ok = 1; m_phase = 1; end
        else if (v == CMD_END && m_phase == 1) begin ok = 1; m_phase = 2; end
      end else if (m_phase == 1) begin
        if (v[1:0] == 2'b11) begin
          if (!mv && int'(v[7:2]) < NT) begin ok = 1; m_tgt = int'(v[7:2]); m_tvld = 1; end
        end else begin
          case (v)
            CMD_GET: if (at && !m_hold && (disp || (m_cont[tg] && !busy))) begin
              ok = 1; m_hold = 1; m_cont[tg] = 0; m_loaded[tg] = 0;
            end
            CMD_PUT: if (at && m_hold && !pend && !disp && !m_cont[tg]) begin
              ok = 1; m_hold = 0; m_cont[tg] = 1;
            end
            CMD_INTERACT: if (at && mach && m_cont[tg] && !busy && !done) begin
              ok = 1; m_loaded[tg] = 1; m_ready[tg] = t + 1 + PC;
            end
            CMD_MOVE: if (m_pos == tg) ok = 1;
                      else if (!mv) begin ok = 1; m_move_end = t + 1 + MC; end
            CMD_THROW: if (m_hold && !mv && !pend) begin
              ok = 1; m_throw_end = t + 1 + TC;
            end
            default: ;
          endcase
        end
      end
      m_ack = ok;
      m_err = !ok;
    end
    if (rel) begin
      m_hold = 0;
      if (rel_dep) m_cont[tg] = 1;
    end
    if (m_move_end == t + 1) m_pos = tg;
    t = t + 1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) m_reset();
    else m_step(link.in_bits);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0d)", nm, act, exp, t);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_out_bits", int'(link.out_bits), int'(m_out()));
      chk("model_cmd_ack", int'(link.cmd_ack), int'(m_ack));
      chk("model_cmd_err", int'(link.cmd_err), int'(m_err));
    end
  end

  task automatic issue(input logic [7:0] v, input bit ea, input bit ee,
                       input logic [7:0] eo, input string nm);
    @(negedge clk); #1 link.in_bits = v;
    @(negedge clk);
    chk({nm, "_ack"}, int'(link.cmd_ack), int'(ea));
    chk({nm, "_err"}, int'(link.cmd_err), int'(ee));
    chk({nm, "_out"}, int'(link.out_bits), int'(eo));
    #1 link.in_bits = 8'h00;
  endtask

  function automatic logic [7:0] pick();
    int r;
    if (m_phase == 0 && $urandom_range(0, 1) == 1) return CMD_START;
    r = $urandom_range(0, 99);
    if (r < 4)  return CMD_START;
    if (r < 5)  return CMD_END;
    if (r < 25) return {6'($urandom_range(0, NT + 3)), 2'b11};
    if (r < 38) return CMD_GET;
    if (r < 50) return CMD_PUT;
    if (r < 60) return CMD_INTERACT;
    if (r < 78) return CMD_MOVE;
    if (r < 88) return CMD_THROW;
    if (r < 94) return 8'h00;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    int n_ack, n_err;
    link.in_bits = 8'h00;
    rst = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("reset_out", int'(link.out_bits), 0);
    #1 rst = 1'b0;

    // 1: commands before start, then start
    issue(CMD_MOVE, 0, 1, 8'h00, "move_idle");
    issue(CMD_START, 1, 0, 8'h01, "start");

    // 2: select dispenser 2, move there, take an item
    issue(8'h0B, 1, 0, 8'h01, "sel2");
    issue(CMD_MOVE, 1, 0, 8'h03, "move2");
    for (int i = 0; i < MC - 1; i++) begin
      @(negedge clk); chk("moving2", int'(link.out_bits[1]), 1);
    end
    @(negedge clk); chk("arrive2", int'(link.out_bits), 8'h05);
    issue(CMD_GET, 1, 0, 8'h0D, "get2");

    // 3: carry to machine 5, load and process it, collect the result
    issue(8'h17, 1, 0, 8'h09, "sel5");
    issue(CMD_MOVE, 1, 0, 8'h0B, "move5");
    repeat (MC - 1) @(negedge clk);
    @(negedge clk); chk("arrive5", int'(link.out_bits), 8'h0D);
    issue(CMD_PUT, 1, 0, 8'h05, "put5");
    issue(CMD_INTERACT, 1, 0, 8'h05, "interact5");
    for (int i = 0; i < PC - 1; i++) begin
      @(negedge clk); chk("busy5", int'(link.out_bits[4]), 0);
    end
    @(negedge clk); chk("done5", int'(link.out_bits), 8'h15);
    issue(CMD_GET, 1, 0, 8'h0D, "get_done5");

    // 4: held level acts once; get while holding rejected
    issue(CMD_PUT, 1, 0, 8'h05, "put5_again");
    n_ack = 0; n_err = 0;
    @(negedge clk); #1 link.in_bits = CMD_GET;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_ack += int'(link.cmd_ack);
      n_err += int'(link.cmd_err);
    end
    chk("held_get_acks", n_ack, 1);
    chk("held_get_errs", n_err, 0);
    #1 link.in_bits = 8'h00;
    issue(CMD_GET, 0, 1, 8'h0D, "get_holding");

    // 5: throw lands on counter 10 selected mid-flight
    issue(CMD_THROW, 1, 0, 8'h0D, "throw");
    issue(8'h2B, 1, 0, 8'h09, "sel10");
    for (int i = 0; i < TC - 3; i++) begin
      @(negedge clk); chk("in_flight", int'(link.out_bits[3]), 1);
    end
    @(negedge clk); chk("released", int'(link.out_bits), 8'h01);
    issue(CMD_THROW, 0, 1, 8'h01, "throw_empty");
    issue(CMD_MOVE, 1, 0, 8'h03, "move10");
    repeat (MC - 1) @(negedge clk);
    @(negedge clk); chk("arrive10", int'(link.out_bits), 8'h05);
    issue(CMD_GET, 1, 0, 8'h0D, "get10_landed");

    // 6: reset mid-move, bad select, end, restart refused
    issue(8'h0B, 1, 0, 8'h09, "sel2b");
    issue(CMD_MOVE, 1, 0, 8'h0B, "move2b");
    repeat (6) @(negedge clk);
    #1 rst = 1'b1;
    #1 chk("async_rst_out", int'(link.out_bits), 0);
    chk("async_rst_ack", int'(link.cmd_ack), 0);
    @(negedge clk); #1 rst = 1'b0;
    issue(CMD_START, 1, 0, 8'h01, "restart");
    issue(8'hFF, 0, 1, 8'h01, "sel63");
    issue(CMD_END, 1, 0, 8'h00, "end");
    issue(CMD_START, 0, 1, 8'h00, "start_ended");

    // Randomized streams, each from a fresh reset
    for (int s = 0; s < 12; s++) begin
      @(negedge clk); #1 rst = 1'b1;
      @(negedge clk); #1 rst = 1'b0;
      for (int n = 0; n < 250; n++) begin
        @(negedge clk); #1 link.in_bits = pick();
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
